// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between two BRAM requesters, the arbiter and one BRAM port.
// The slave modport is the arbiter's view, and the master modport is the opposite side.
interface bram_port_arbiter_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              req0_i;
    logic              we0_i;
    logic [AWIDTH-1:0] addr0_i;
    logic [DWIDTH-1:0] d0_i;
    logic              req1_i;
    logic              we1_i;
    logic [AWIDTH-1:0] addr1_i;
    logic [DWIDTH-1:0] d1_i;
    logic              gnt0_o;
    logic              gnt1_o;
    logic [DWIDTH-1:0] q0_o;
    logic [DWIDTH-1:0] q1_o;
    logic              q_valid0_o;
    logic              q_valid1_o;
    logic              busy_o;
    logic [DWIDTH-1:0] q_i;
    logic [AWIDTH-1:0] addr_o;
    logic              ce_o;
    logic              we_o;
    logic [DWIDTH-1:0] d_o;

    modport slave (
        input  req0_i, we0_i, addr0_i, d0_i,
        input  req1_i, we1_i, addr1_i, d1_i,
        output gnt0_o, gnt1_o,
        output q0_o, q1_o, q_valid0_o, q_valid1_o,
        output busy_o,
        input  q_i,
        output addr_o, ce_o, we_o, d_o
    );

    modport master (
        output req0_i, we0_i, addr0_i, d0_i,
        output req1_i, we1_i, addr1_i, d1_i,
        input  gnt0_o, gnt1_o,
        input  q0_o, q1_o, q_valid0_o, q_valid1_o,
        input  busy_o,
        output q_i,
        input  addr_o, ce_o, we_o, d_o
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one BRAM port.
// Ties go to the requester served least recently, bursts are bounded while the other side waits, and read data is steered back to the requester that issued the read.
module bram_port_arbiter #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 16
) (
    input logic              clk,
    input logic              reset,
    bram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

    state_t            state;
    state_t            next_state;
    logic              last_id;
    logic [7:0]        cnt;
    logic              rd_pend;
    logic              rd_owner;

    logic              acc0;
    logic              acc1;
    logic              acc;
    logic              enter0;
    logic              enter1;
    logic              at_limit;
    logic              mux_we;
    logic [AWIDTH-1:0] mux_addr;
    logic [DWIDTH-1:0] mux_d;

    // An access happens only when the grant and the request line are high together.
    always_comb begin
        acc0     = (state == GRANT0) && bus.req0_i;
        acc1     = (state == GRANT1) && bus.req1_i;
        acc      = acc0 || acc1;
        at_limit = (cnt == LAST);
    end

    // Drive the BRAM port from the requester that is accessing it, and drive zeros otherwise.
    always_comb begin
        mux_we   = 1'b0;
        mux_addr = '0;
        mux_d    = '0;
        if (acc0) begin
            mux_we   = bus.we0_i;
            mux_addr = bus.addr0_i;
            mux_d    = bus.d0_i;
        end else if (acc1) begin
            mux_we   = bus.we1_i;
            mux_addr = bus.addr1_i;
            mux_d    = bus.d1_i;
        end
    end

    // Next-state logic: arbitrate ties, hand over the grant when a request drops, and cap bursts.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.req0_i && bus.req1_i)
                    next_state = last_id ? GRANT0 : GRANT1;
                else if (bus.req0_i)
                    next_state = GRANT0;
                else if (bus.req1_i)
                    next_state = GRANT1;
            end
            GRANT0: begin
                if (!bus.req0_i)
                    next_state = bus.req1_i ? GRANT1 : IDLE;
                else if (at_limit && bus.req1_i)
                    next_state = GRANT1;
            end
            GRANT1: begin
                if (!bus.req1_i)
                    next_state = bus.req0_i ? GRANT0 : IDLE;
                else if (at_limit && bus.req0_i)
                    next_state = GRANT0;
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant entry is a move into a GRANT state from any other state.
    always_comb begin
        enter0 = (next_state == GRANT0) && (state != GRANT0);
        enter1 = (next_state == GRANT1) && (state != GRANT1);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Record the requester granted most recently so that a tie goes to the other one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_id <= 1'b1;
        else if (enter0)
            last_id <= 1'b0;
        else if (enter1)
            last_id <= 1'b1;
    end

    // Burst counter: clears on grant entry and at the burst limit, and counts each access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 8'd0;
        else if (enter0 || enter1)
            cnt <= 8'd0;
        else if (acc)
            cnt <= at_limit ? 8'd0 : cnt + 8'd1;
    end

    // Remember each read and its owner, because the data returns on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= acc && !mux_we;
            rd_owner <= acc1;
        end
    end

    // Output assignments: the grants follow the state, and read data goes straight through to both requesters.
    always_comb begin
        bus.gnt0_o     = (state == GRANT0);
        bus.gnt1_o     = (state == GRANT1);
        bus.busy_o     = (state != IDLE);
        bus.ce_o       = acc;
        bus.we_o       = mux_we;
        bus.addr_o     = mux_addr;
        bus.d_o        = mux_d;
        bus.q0_o       = bus.q_i;
        bus.q1_o       = bus.q_i;
        bus.q_valid0_o = rd_pend && !rd_owner;
        bus.q_valid1_o = rd_pend && rd_owner;
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with MAX_BURST set to 4.
// A cycle table covers the basic accesses, and hand-written sequences cover bursts and reset.
module tb_bram_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.AWIDTH(10), .DWIDTH(32)) bus ();

    bram_port_arbiter #(
        .AWIDTH(10),
        .DWIDTH(32),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        r0;
        logic        w0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [31:0] q;
        logic        g0;
        logic        g1;
        logic        ce;
        logic        we;
        logic [9:0]  ea;
        logic [31:0] ed;
        logic        qv0;
        logic        qv1;
        logic        busy;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0,
                         input logic [9:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1,
                         input logic [9:0] a1, input logic [31:0] d1,
                         input logic [31:0] q);
        bus.req0_i  = r0;
        bus.we0_i   = w0;
        bus.addr0_i = a0;
        bus.d0_i    = d0;
        bus.req1_i  = r1;
        bus.we1_i   = w1;
        bus.addr1_i = a1;
        bus.d1_i    = d1;
        bus.q_i     = q;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[0]  = '{1,1,10'h00A,32'hA0, 1,0,10'h01B,32'hB0, 32'h0,
                   0,0,0,0,10'h0,32'h0,0,0,0};
        vt[1]  = '{1,1,10'h00A,32'hA0, 1,0,10'h01B,32'hB0, 32'h0,
                   1,0,1,1,10'h00A,32'hA0,0,0,1};
        vt[2]  = '{0,1,10'h00A,32'hA0, 1,0,10'h01B,32'hB0, 32'h0,
                   1,0,0,0,10'h0,32'h0,0,0,1};
        vt[3]  = '{0,0,10'h0,32'h0, 1,0,10'h01B,32'hB0, 32'h0,
                   0,1,1,0,10'h01B,32'hB0,0,0,1};
        vt[4]  = '{0,0,10'h0,32'h0, 0,0,10'h0,32'h0, 32'h12345678,
                   0,1,0,0,10'h0,32'h0,0,1,1};
        vt[5]  = '{0,0,10'h0,32'h0, 0,0,10'h0,32'h0, 32'h0,
                   0,0,0,0,10'h0,32'h0,0,0,0};
        vt[6]  = '{1,0,10'h005,32'h11, 0,0,10'h0,32'h0, 32'h0,
                   0,0,0,0,10'h0,32'h0,0,0,0};
        vt[7]  = '{1,0,10'h005,32'h11, 0,0,10'h0,32'h0, 32'h0,
                   1,0,1,0,10'h005,32'h11,0,0,1};
        vt[8]  = '{0,0,10'h0,32'h0, 0,0,10'h0,32'h0, 32'hCAFE0001,
                   1,0,0,0,10'h0,32'h0,1,0,1};
        vt[9]  = '{0,0,10'h0,32'h0, 0,0,10'h0,32'h0, 32'h0,
                   0,0,0,0,10'h0,32'h0,0,0,0};
        vt[10] = '{0,0,10'h0,32'h0, 1,1,10'h3FF,32'hFFFFFFFF, 32'h0,
                   0,0,0,0,10'h0,32'h0,0,0,0};
        vt[11] = '{0,0,10'h0,32'h0, 1,1,10'h3FF,32'hFFFFFFFF, 32'h0,
                   0,1,1,1,10'h3FF,32'hFFFFFFFF,0,0,1};
        vt[12] = '{0,0,10'h0,32'h0, 0,0,10'h0,32'h0, 32'h5A5A5A5A,
                   0,1,0,0,10'h0,32'h0,0,0,1};
        vt[13] = '{0,0,10'h0,32'h0, 0,0,10'h0,32'h0, 32'h0,
                   0,0,0,0,10'h0,32'h0,0,0,0};

        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt0", 32'(bus.gnt0_o), 32'(1'b0));
        chk("rst_gnt1", 32'(bus.gnt1_o), 32'(1'b0));
        chk("rst_busy", 32'(bus.busy_o), 32'(1'b0));
        chk("rst_ce", 32'(bus.ce_o), 32'(1'b0));
        chk("rst_qv0", 32'(bus.q_valid0_o), 32'(1'b0));
        chk("rst_qv1", 32'(bus.q_valid1_o), 32'(1'b0));
        @(negedge clk);
        reset = 1'b0;

        // Cycle table.
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
                  vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].q);
            #1;
            chk($sformatf("v%0d_gnt0", i), 32'(bus.gnt0_o), 32'(vt[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(bus.gnt1_o), 32'(vt[i].g1));
            chk($sformatf("v%0d_ce", i), 32'(bus.ce_o), 32'(vt[i].ce));
            chk($sformatf("v%0d_we", i), 32'(bus.we_o), 32'(vt[i].we));
            chk($sformatf("v%0d_addr", i), 32'(bus.addr_o), 32'(vt[i].ea));
            chk($sformatf("v%0d_d", i), bus.d_o, vt[i].ed);
            chk($sformatf("v%0d_qv0", i), 32'(bus.q_valid0_o), 32'(vt[i].qv0));
            chk($sformatf("v%0d_qv1", i), 32'(bus.q_valid1_o), 32'(vt[i].qv1));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'(vt[i].busy));
            chk($sformatf("v%0d_q0", i), bus.q0_o, vt[i].q);
            chk($sformatf("v%0d_q1", i), bus.q1_o, vt[i].q);
        end

        // Starvation limit: both requests held, so the grant alternates every 4 accesses.
        do_reset();
        drive(1, 1, 10'h010, 32'h1, 1, 1, 10'h020, 32'h2, 0);
        #1;
        chk("sv_idle_ce", 32'(bus.ce_o), 32'(1'b0));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("sv%0d_ce", k), 32'(bus.ce_o), 32'(1'b1));
            chk($sformatf("sv%0d_gnt0", k), 32'(bus.gnt0_o),
                32'(((k / 4) % 2) == 0));
            chk($sformatf("sv%0d_gnt1", k), 32'(bus.gnt1_o),
                32'(((k / 4) % 2) == 1));
        end

        // Lone burst: only requester 0, so 10 accesses with no drop in the grant.
        do_reset();
        drive(1, 1, 10'h033, 32'h3, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lb%0d_ce", k), 32'(bus.ce_o), 32'(1'b1));
            chk($sformatf("lb%0d_gnt0", k), 32'(bus.gnt0_o), 32'(1'b1));
        end

        // Read at the burst boundary: the final read by requester 0 returns during GRANT1.
        do_reset();
        drive(1, 0, 10'h044, 32'h0, 1, 1, 10'h055, 32'h9, 32'hBEEF0000);
        repeat (5) @(negedge clk);
        #1;
        chk("bb_gnt1", 32'(bus.gnt1_o), 32'(1'b1));
        chk("bb_qv0", 32'(bus.q_valid0_o), 32'(1'b1));
        chk("bb_qv1", 32'(bus.q_valid1_o), 32'(1'b0));
        chk("bb_q0", bus.q0_o, 32'hBEEF0000);
        @(negedge clk);
        #1;
        chk("bb2_qv0", 32'(bus.q_valid0_o), 32'(1'b0));
        chk("bb2_qv1", 32'(bus.q_valid1_o), 32'(1'b0));

        // Reset mid-burst with a read still in flight.
        do_reset();
        drive(1, 0, 10'h066, 32'h0, 0, 0, 0, 0, 32'h77);
        @(negedge clk);
        #1;
        chk("mr_ce_pre", 32'(bus.ce_o), 32'(1'b1));
        @(posedge clk);
        #1;
        chk("mr_qv0_pre", 32'(bus.q_valid0_o), 32'(1'b1));
        reset = 1'b1;
        #1;
        chk("mr_gnt0_async", 32'(bus.gnt0_o), 32'(1'b0));
        chk("mr_ce_async", 32'(bus.ce_o), 32'(1'b0));
        chk("mr_qv0_async", 32'(bus.q_valid0_o), 32'(1'b0));
        @(posedge clk);
        #1;
        chk("mr_gnt0_edge", 32'(bus.gnt0_o), 32'(1'b0));
        chk("mr_we_edge", 32'(bus.we_o), 32'(1'b0));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("mr_busy_after", 32'(bus.busy_o), 32'(1'b0));
        chk("mr_qv0_after", 32'(bus.q_valid0_o), 32'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter AWIDTH, default 10, BRAM address width.
REQ-002 Parameter DWIDTH, default 32, BRAM data width.
REQ-003 Parameter MAX_BURST, default 16, maximum consecutive accesses per grant while the other requester waits (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0_i / req1_i  input  1  access request, requester 0 / 1; held high for the whole burst.
REQ-007 we0_i / we1_i  input  1  1 = write, 0 = read, per requester.
REQ-008 addr0_i / addr1_i  input  AWIDTH  access address, per requester.
REQ-009 d0_i / d1_i  input  DWIDTH  write data, per requester.
REQ-010 gnt0_o / gnt1_o  output  1  registered grant, per requester.
REQ-011 q0_o / q1_o  output  DWIDTH  read data, per requester.
REQ-012 q_valid0_o / q_valid1_o  output  1  read data valid, per requester.
REQ-013 busy_o  output  1  high in any GRANT state.
REQ-014 q_i  input  DWIDTH  BRAM read data, valid 1 cycle after a read access.
REQ-015 addr_o  output  AWIDTH  BRAM address.
REQ-016 ce_o  output  1  BRAM chip enable.
REQ-017 we_o  output  1  BRAM write enable.
REQ-018 d_o  output  DWIDTH  BRAM write data.

Function
REQ-019 FSM states: IDLE, GRANT0, GRANT1; gnt0_o = (state==GRANT0), gnt1_o = (state==GRANT1).
REQ-020 An access occurs in a cycle iff gntX_o and reqX_i are both high; ce_o = that access, combinational.
REQ-021 we_o, addr_o, d_o = granted requester's inputs during an access; all 0 otherwise.
REQ-022 IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> requester not served last (last_id register); none -> stay IDLE.
REQ-023 Request-to-grant latency: exactly 1 cycle from IDLE.
REQ-024 GRANTx with reqX_i low: no access; next state GRANTy if reqY_i high, else IDLE.
REQ-025 Burst counter clears on grant entry and increments per access (8-bit).
REQ-026 Access with counter == MAX_BURST-1 and reqY_i high: next state GRANTy (no idle gap); counter clears.
REQ-027 Same case with reqY_i low: counter clears, grant to X retained.
REQ-028 last_id updates to X on every entry into GRANTx.
REQ-029 Read return: registered rd_pend and rd_owner capture each read access; next cycle q_validX_o = rd_pend & (rd_owner==X).
REQ-030 q0_o and q1_o = q_i unconditionally; consumers qualify with q_valid.
REQ-031 A read issued in the last cycle of a grant still returns to its owner after the grant switches.
REQ-032 Writes produce no q_valid pulse.
REQ-033 busy_o = (state != IDLE).

Reset
REQ-034 While reset is high: state IDLE, last_id = 1 (requester 0 wins first tie), counter 0, rd_pend 0.
REQ-035 Reset asserted mid-burst: all gnt, ce_o, we_o and q_valid outputs drop to 0 immediately (asynchronously); the in-flight read is discarded.
REQ-036 First grant possible 1 cycle after the first rising edge with reset low.

Verification
REQ-037 Single read: req0 with addr 0x005, we=0 -> gnt0 next cycle, ce_o=1, addr_o=0x005; q_valid0_o=1 one cycle later with q0_o = q_i.
REQ-038 Tie after reset: req0 and req1 rise together -> GRANT0 first; after req0 drops, GRANT1 in the following cycle.
REQ-039 Starvation limit, MAX_BURST=4, req0 and req1 held high -> exactly 4 accesses by 0, then 4 by 1, alternating with no gap cycles.
REQ-040 Lone burst, MAX_BURST=4, only req0 for 10 cycles -> 10 consecutive accesses; gnt0 never drops.
REQ-041 Read at burst boundary: last access of requester 0 is a read -> q_valid0_o pulses in the first GRANT1 cycle; q_valid1_o stays 0.
REQ-042 Reset mid-burst after a read access -> gnt0_o, ce_o and q_valid0_o are 0 on the following edge; state is IDLE after reset releases.
